// File: rtl/stuff_serializer_pkg.sv
// Shared types and defaults for the bit-stuffing serializer.
// The PARITY state only exists when PARITY_EN is defined.
package stuff_tx_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_MAX_RUN = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        STUFF  = 2'd2
`ifdef PARITY_EN
        , PARITY = 2'd3
`endif
    } state_t;

    function automatic int run_cnt_w(input int max_run);
        return $clog2(max_run + 1);
    endfunction

endpackage

// File: rtl/stuff_serializer_run_tracker.sv
// Tracks the run of equal line bits and flags when the current run has reached MAX_RUN.
// A strobe together with clear starts a fresh run with the strobed bit.
module run_tracker
    import stuff_tx_pkg::*;
#(
    parameter int MAX_RUN = DEF_MAX_RUN
) (
    input  logic clk,
    input  logic rst,
    input  logic line_bit,
    input  logic strobe,
    input  logic clear,
    output logic last_bit,
    output logic need_stuff
);

    localparam int CW = run_cnt_w(MAX_RUN);

    logic [CW-1:0] run_cnt;
    logic [CW:0]   ext_cnt;
    logic [CW:0]   nxt_cnt;

    // Saturate at MAX_RUN so a narrow counter never wraps.
    always_comb begin
        ext_cnt = {1'b0, run_cnt};
        if (clear || run_cnt == '0 || line_bit != last_bit) begin
            nxt_cnt = (CW+1)'(1);
        end else begin
            nxt_cnt = ext_cnt + 1'b1;
        end
        if (nxt_cnt > (CW+1)'(MAX_RUN)) begin
            nxt_cnt = (CW+1)'(MAX_RUN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt  <= '0;
            last_bit <= 1'b0;
        end else if (strobe) begin
            run_cnt  <= nxt_cnt[CW-1:0];
            last_bit <= line_bit;
        end else if (clear) begin
            run_cnt <= '0;
        end
    end

    assign need_stuff = (run_cnt == CW'(MAX_RUN));

endmodule

// File: rtl/stuff_serializer.sv
// LSB-first serializer that inserts a complementary stuff bit after every MAX_RUN equal bits.
// Define PARITY_EN to append an even-parity bit (itself subject to stuffing) to each frame.
module stuff_serializer
    import stuff_tx_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_RUN = DEF_MAX_RUN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx_bit,
    output logic              tx_en,
    output logic              busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // state names the kind of bit currently on the line.
    state_t            state;
    state_t            nxt_state;
    state_t            res_state;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] shifted;
    logic [IDX_W-1:0]  idx;
    logic              last_data;
    logic              res_drv;
    logic              res_bit;
    logic              drv;
    logic              drv_bit;
    logic              load;
    logic              trk_clear;
    logic              last_bit;
    logic              need_stuff;
`ifdef PARITY_EN
    logic              par;
    logic              par_sent;
`endif

    assign shifted   = sreg >> 1;
    assign last_data = (idx == IDX_W'(DATA_W - 1));

    // What follows a data or stuff bit when no new stuff bit is due.
    always_comb begin
        res_state = IDLE;
        res_drv   = 1'b0;
        res_bit   = 1'b0;
        if (!last_data) begin
            res_state = DATA;
            res_drv   = 1'b1;
            res_bit   = shifted[0];
        end
`ifdef PARITY_EN
        else if (!par_sent) begin
            res_state = PARITY;
            res_drv   = 1'b1;
            res_bit   = par;
        end
`endif
    end

    always_comb begin
        nxt_state = state;
        drv       = 1'b0;
        drv_bit   = 1'b0;
        load      = 1'b0;
        trk_clear = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    trk_clear = 1'b1;
                    drv       = 1'b1;
                    drv_bit   = in_data[0];
                    nxt_state = DATA;
                end
            end
            DATA: begin
                if (need_stuff) begin
                    nxt_state = STUFF;
                    drv       = 1'b1;
                    drv_bit   = ~last_bit;
                end else begin
                    nxt_state = res_state;
                    drv       = res_drv;
                    drv_bit   = res_bit;
                end
            end
            STUFF: begin
                nxt_state = res_state;
                drv       = res_drv;
                drv_bit   = res_bit;
            end
`ifdef PARITY_EN
            PARITY: begin
                if (need_stuff) begin
                    nxt_state = STUFF;
                    drv       = 1'b1;
                    drv_bit   = ~last_bit;
                end else begin
                    nxt_state = IDLE;
                end
            end
`endif
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            tx_bit <= 1'b0;
            tx_en  <= 1'b0;
            sreg   <= '0;
            idx    <= '0;
`ifdef PARITY_EN
            par      <= 1'b0;
            par_sent <= 1'b0;
`endif
        end else begin
            state  <= nxt_state;
            tx_bit <= drv_bit;
            tx_en  <= drv;
            if (load) begin
                sreg <= in_data;
                idx  <= '0;
            end else if (nxt_state == DATA) begin
                sreg <= shifted;
                idx  <= idx + 1'b1;
            end
`ifdef PARITY_EN
            if (load) begin
                par      <= ^in_data;
                par_sent <= 1'b0;
            end else if (nxt_state == PARITY) begin
                par_sent <= 1'b1;
            end
`endif
        end
    end

    run_tracker #(
        .MAX_RUN(MAX_RUN)
    ) u_run_tracker (
        .clk       (clk),
        .rst       (rst),
        .line_bit  (drv_bit),
        .strobe    (drv),
        .clear     (trk_clear),
        .last_bit  (last_bit),
        .need_stuff(need_stuff)
    );

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_stuff_serializer.sv
// Bench for stuff_serializer (DATA_W=8, MAX_RUN=2); honours PARITY_EN when defined.
module tb_stuff_serializer;

    localparam int DATA_W  = 8;
    localparam int MAX_RUN = 2;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              tx_bit;
    logic              tx_en;
    logic              busy;

    int checks;
    int errors;

    typedef struct {
        logic [7:0]  data;
        int          len;
        logic [31:0] bits;
    } vec_t;

    vec_t vecs[4];

    stuff_serializer #(
        .DATA_W (DATA_W),
        .MAX_RUN(MAX_RUN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .tx_bit  (tx_bit),
        .tx_en   (tx_en),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: payload bits LSB first (+ parity), then walk the line run by run.
    function automatic void model(input logic [7:0] d, output logic [31:0] bits, output int len);
        logic pay[$];
        int   run;
        logic last;
        bits = '0;
        len  = 0;
        run  = 0;
        last = 1'b0;
        for (int i = 0; i < DATA_W; i++) pay.push_back(d[i]);
`ifdef PARITY_EN
        pay.push_back(^d);
`endif
        foreach (pay[k]) begin
            bits[len] = pay[k];
            len++;
            run  = (run > 0 && pay[k] == last) ? run + 1 : 1;
            last = pay[k];
            if (run == MAX_RUN) begin
                bits[len] = ~last;
                len++;
                last = ~last;
                run  = 1;
            end
        end
    endfunction

    function automatic int longest_run(input logic [31:0] bits, input int len);
        int best;
        int run;
        best = 0;
        run  = 0;
        for (int i = 0; i < len; i++) begin
            run  = (i > 0 && bits[i] == bits[i-1]) ? run + 1 : 1;
            best = (run > best) ? run : best;
        end
        return best;
    endfunction

    // Call at a negedge; returns just after the accepting posedge.
    task automatic send(input logic [7:0] d, input bit hold);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    // Samples line bits at negedges until tx_en drops; returns at that idle negedge.
    task automatic collect(output logic [31:0] bits, output int len);
        int   guard;
        logic busy_ok;
        bits    = '0;
        len     = 0;
        busy_ok = 1'b1;
        guard   = 0;
        @(negedge clk);
        while (tx_en && guard < 32) begin
            bits[len] = tx_bit;
            if (!busy) busy_ok = 1'b0;
            len++;
            guard++;
            @(negedge clk);
        end
        check("frame_bounded", 32'(guard < 32), 32'd1);
        check("busy_in_frame", 32'(busy_ok), 32'd1);
        check("idle_after_frame", {29'd0, in_ready, busy, tx_en}, 32'b100);
    endtask

    task automatic check_frame(input string name, input logic [31:0] bits, input int len,
                               input logic [31:0] exp_bits, input int exp_len);
        check({name, "_len"}, 32'(len), 32'(exp_len));
        check({name, "_bits"}, bits, exp_bits);
    endtask

    initial begin
        logic [31:0] bits;
        logic [31:0] exp_bits;
        int          len;
        int          exp_len;
        logic [7:0]  d;

        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

`ifdef PARITY_EN
        vecs[0] = '{8'h55, 10, 32'h0255};
        vecs[1] = '{8'h00, 13, 32'h0924};
        vecs[2] = '{8'hFF, 14, 32'h26DB};
        vecs[3] = '{8'hA5, 14, 32'h2665};
`else
        vecs[0] = '{8'h55, 8,  32'h0055};
        vecs[1] = '{8'h00, 12, 32'h0924};
        vecs[2] = '{8'hFF, 12, 32'h06DB};
        vecs[3] = '{8'hA5, 12, 32'h0665};
`endif

        // Reset and idle
        repeat (3) begin
            @(negedge clk);
            check("in_reset", {28'd0, in_ready, tx_en, tx_bit, busy}, 32'h0);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle", {28'd0, in_ready, tx_en, tx_bit, busy}, 32'h8);
        end

        // Directed patterns from the table
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].data, 1'b0);
            collect(bits, len);
            check_frame($sformatf("vec_%0h", vecs[i].data), bits, len, vecs[i].bits, vecs[i].len);
        end

        // Randomized frames against the reference model
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom_range(255, 0));
            model(d, exp_bits, exp_len);
            send(d, 1'b0);
            collect(bits, len);
            check_frame($sformatf("rand_%0h", d), bits, len, exp_bits, exp_len);
            check("rand_max_run", 32'(longest_run(bits, len) <= MAX_RUN), 32'd1);
        end

        // Abort mid-frame on 8'h00 while a stuff bit is on the line
        send(8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_pre_bit", {30'd0, tx_en, tx_bit}, 32'b11);
        #2;
        rst = 1'b1;
        #1;
        check("abort_async", {28'd0, in_ready, tx_en, tx_bit, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_recover_ready", 32'(in_ready), 32'd1);
        send(8'h55, 1'b0);
        collect(bits, len);
        check_frame("after_abort", bits, len, vecs[0].bits, vecs[0].len);

        // Back-to-back: in_valid held high across two frames
        send(vecs[0].data, 1'b1);
        in_data = vecs[3].data;
        collect(bits, len);
        check_frame("b2b_first", bits, len, vecs[0].bits, vecs[0].len);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        collect(bits, len);
        check_frame("b2b_second", bits, len, vecs[3].bits, vecs[3].len);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
